// File: rtl/bus_rtc_pkg.sv
// Shared definitions for the RTC bus-timing stages: state encoding, default
// phase lengths and idle levels for the bus control lines.
package bus_rtc_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_REQ_A    = 4'd1;
    localparam logic [3:0] ST_LOAD_A   = 4'd2;
    localparam logic [3:0] ST_A_SET    = 4'd3;
    localparam logic [3:0] ST_A_STB    = 4'd4;
    localparam logic [3:0] ST_A_HLD    = 4'd5;
    localparam logic [3:0] ST_REQ_D    = 4'd6;
    localparam logic [3:0] ST_LOAD_D   = 4'd7;
    localparam logic [3:0] ST_D_SET    = 4'd8;
    localparam logic [3:0] ST_D_STB    = 4'd9;
    localparam logic [3:0] ST_D_HLD    = 4'd10;
    localparam logic [3:0] ST_GAP      = 4'd11;
    localparam logic [3:0] ST_FIN      = 4'd12;
    localparam logic [3:0] ST_WAIT_LOW = 4'd13;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        REQ_A    = ST_REQ_A,
        LOAD_A   = ST_LOAD_A,
        A_SET    = ST_A_SET,
        A_STB    = ST_A_STB,
        A_HLD    = ST_A_HLD,
        REQ_D    = ST_REQ_D,
        LOAD_D   = ST_LOAD_D,
        D_SET    = ST_D_SET,
        D_STB    = ST_D_STB,
        D_HLD    = ST_D_HLD,
        GAP      = ST_GAP,
        FIN      = ST_FIN,
        WAIT_LOW = ST_WAIT_LOW
    } estado_t;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_PULSE_DEF = 4;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_GAP_DEF   = 2;
    localparam int unsigned CW_DEF      = 4;

    localparam logic CS_N_IDLE = 1'b1;
    localparam logic WR_N_IDLE = 1'b1;
    localparam logic RD_N_IDLE = 1'b1;

    // States whose length is set by the phase counter.
    function automatic logic es_temporizado(estado_t e);
        return (e == A_SET) || (e == A_STB) || (e == A_HLD) ||
               (e == D_SET) || (e == D_STB) || (e == D_HLD) || (e == GAP);
    endfunction

    // States in which the RTC bus is selected and AD is driven.
    function automatic logic bus_activo(estado_t e);
        return (e == A_SET) || (e == A_STB) || (e == A_HLD) ||
               (e == D_SET) || (e == D_STB) || (e == D_HLD);
    endfunction

endpackage

// File: rtl/contador_fase_bus.sv
// Loadable down-counter that times bus phases; saturates at zero.
module contador_fase_bus #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] carga,
    output logic [CW-1:0] valor,
    output logic          cero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (load) begin
            valor <= carga;
        end else if (valor != '0) begin
            valor <= valor - 1'b1;
        end
    end

    assign cero = (valor == '0);

endmodule

// File: rtl/bus_rtc_escritura.sv
// RTC write bus-timing stage: fetches address and data bytes from the write
// sequencer and drives them on the multiplexed bus with programmable timing.
module bus_rtc_escritura
    import bus_rtc_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_esc,
    input  logic [7:0] Dato_Dire,
    output logic       DIR,
    output logic       DAT,
    output logic       cambio_estado,
    output logic [7:0] AD,
    output logic       AD_oe,
    output logic       CS_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       A_D,
    output logic       ocupado
);

    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(T_GAP - 1);

    estado_t       estado, estado_d;
    logic          cnt_load;
    logic [CW-1:0] cnt_carga;
    logic [CW-1:0] cuenta_unused;
    logic          cnt_cero;

    contador_fase_bus #(
        .CW(CW)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .carga (cnt_carga),
        .valor (cuenta_unused),
        .cero  (cnt_cero)
    );

    always_comb begin
        estado_d = estado;
        unique case (estado)
            IDLE:     if (E_esc) estado_d = REQ_A;
            REQ_A:    estado_d = LOAD_A;
            LOAD_A:   estado_d = A_SET;
            A_SET:    if (cnt_cero) estado_d = A_STB;
            A_STB:    if (cnt_cero) estado_d = A_HLD;
            A_HLD:    if (cnt_cero) estado_d = REQ_D;
            REQ_D:    estado_d = LOAD_D;
            LOAD_D:   estado_d = D_SET;
            D_SET:    if (cnt_cero) estado_d = D_STB;
            D_STB:    if (cnt_cero) estado_d = D_HLD;
            D_HLD:    if (cnt_cero) estado_d = GAP;
            GAP:      if (cnt_cero) estado_d = FIN;
            FIN:      estado_d = WAIT_LOW;
            // The sequencer keeps E_esc high until it has seen cambio_estado.
            WAIT_LOW: if (!E_esc) estado_d = IDLE;
            default:  estado_d = IDLE;
        endcase
    end

    // Counter is preloaded on the edge that enters a timed state.
    always_comb begin
        cnt_carga = '0;
        case (estado_d)
            A_SET, D_SET: cnt_carga = C_SETUP;
            A_STB, D_STB: cnt_carga = C_PULSE;
            A_HLD, D_HLD: cnt_carga = C_HOLD;
            GAP:          cnt_carga = C_GAP;
            default:      cnt_carga = '0;
        endcase
        cnt_load = (estado_d != estado) && es_temporizado(estado_d);
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado        <= IDLE;
            AD            <= 8'h00;
            AD_oe         <= 1'b0;
            CS_n          <= CS_N_IDLE;
            WR_n          <= WR_N_IDLE;
            RD_n          <= RD_N_IDLE;
            A_D           <= 1'b0;
            DIR           <= 1'b0;
            DAT           <= 1'b0;
            cambio_estado <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            estado        <= estado_d;
            AD_oe         <= bus_activo(estado_d);
            CS_n          <= bus_activo(estado_d) ? 1'b0 : CS_N_IDLE;
            WR_n          <= ((estado_d == A_STB) || (estado_d == D_STB)) ? 1'b0 : WR_N_IDLE;
            RD_n          <= RD_N_IDLE;
            A_D           <= (estado_d == D_SET) || (estado_d == D_STB) || (estado_d == D_HLD);
            DIR           <= (estado_d == REQ_A);
            DAT           <= (estado_d == REQ_D);
            cambio_estado <= (estado_d == FIN);
            ocupado       <= (estado_d != IDLE);
            if ((estado == LOAD_A) || (estado == LOAD_D)) begin
                AD <= Dato_Dire;
            end
        end
    end

endmodule

// File: doc/bus_rtc_escritura.md
# bus_rtc_escritura

Bus-timing stage directly downstream of the RTC write sequencer. For each register write, it requests the address byte and then the data byte from the sequencer using single-cycle `DIR`/`DAT` pulses. It drives both bytes onto the RTC's multiplexed address/data bus with programmable setup, strobe and hold times. It then returns a single-cycle `cambio_estado` so the sequencer advances to its next register.

## Interface
Parameters:
- `T_SETUP`, default 2: cycles of `AD` and `CS_n` valid before `WR_n` falls. Minimum 1.
- `T_PULSE`, default 4: cycles `WR_n` is held low. Minimum 1.
- `T_HOLD`, default 2: cycles `AD` and `CS_n` stay valid after `WR_n` rises. Minimum 1.
- `T_GAP`, default 2: idle cycles between the data phase and `cambio_estado`. Minimum 1.
- `CW`, default 4: phase-counter width. Every `T_*` parameter must be ≤ 2^CW.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low. The block is in reset while `reset` = 0.
- `E_esc` in 1: write enable from the sequencer.
- `Dato_Dire` in 8: address/data byte from the sequencer.
- `DIR` out 1: one-cycle address request.
- `DAT` out 1: one-cycle data request.
- `cambio_estado` out 1: one-cycle transaction-complete pulse.
- `AD` out 8: bus byte.
- `AD_oe` out 1: tristate enable for `AD`.
- `CS_n` out 1: chip select, active-low.
- `WR_n` out 1: write strobe, active-low.
- `RD_n` out 1: read strobe. Held at 1 (write-only block).
- `A_D` out 1: bus phase select, 0 = address, 1 = data.
- `ocupado` out 1: high whenever the FSM is not in IDLE.

## Operation
- All outputs are registered.
- Reset values: `AD` = 0x00, `AD_oe` = 0, `CS_n` = 1, `WR_n` = 1, `RD_n` = 1, `A_D` = 0, `DIR` = 0, `DAT` = 0, `cambio_estado` = 0, `ocupado` = 0. Counter = 0, state = IDLE.
- FSM states and transitions:
  - IDLE → REQ_A when `E_esc` = 1.
  - REQ_A (`DIR` = 1) → LOAD_A.
  - LOAD_A → A_SET. `Dato_Dire` is latched into `AD` at the end of LOAD_A.
  - A_SET → A_STB → A_HLD. `A_D` = 0 in all three.
  - A_HLD → REQ_D.
  - REQ_D (`DAT` = 1) → LOAD_D. `Dato_Dire` is latched at the end of LOAD_D.
  - LOAD_D → D_SET → D_STB → D_HLD. `A_D` = 1 in all three.
  - D_HLD → GAP → FIN.
  - FIN (`cambio_estado` = 1) → WAIT_LOW.
  - WAIT_LOW → IDLE once `E_esc` = 0.
- Outputs per phase:
  - `CS_n` = 0 and `AD_oe` = 1 throughout the *_SET, *_STB and *_HLD states only.
  - `WR_n` = 0 only in *_STB.
  - `A_D` holds its value through REQ_D and LOAD_D (stays 0) and returns to 0 in GAP.
- Each timed state loads the counter with `T_x` − 1 on entry and exits when the counter reads 0.
- `E_esc` is ignored outside IDLE and WAIT_LOW. A drop mid-transaction does not abort the transaction.
- WAIT_LOW is required because the sequencer drops `E_esc` for exactly one cycle after `cambio_estado` and then re-raises it for the next register. Without WAIT_LOW, the stale high would start a duplicate transaction.
- `AD` retains the last driven byte while `AD_oe` = 0.

## Timing
- Cycle numbering: cycle 0 is the first cycle in which `E_esc` is high while in IDLE.
- With default parameters:
  - `DIR` is high in cycle 1.
  - A_SET occupies cycles 3–4, A_STB 5–8, A_HLD 9–10.
  - `DAT` is high in cycle 11.
  - D_SET occupies cycles 13–14, D_STB 15–18, D_HLD 19–20.
  - GAP occupies cycles 21–22.
  - `cambio_estado` is high in cycle 23.
- General latency from cycle 0 to `cambio_estado`: 5 + 2·(`T_SETUP` + `T_PULSE` + `T_HOLD`) + `T_GAP` cycles.
- The sequencer updates `Dato_Dire` one cycle after seeing `DIR`/`DAT`. The block samples `Dato_Dire` in the LOAD state, never in the REQ state.
- If `E_esc` is already 0 in FIN, WAIT_LOW lasts one cycle.
- Asserting `reset` mid-strobe returns all outputs to their reset values immediately. `CS_n` and `WR_n` go high asynchronously.

## Structure
- Shared package `bus_rtc_pkg` holds:
  - the state encoding for the 14 states, as 4-bit localparams;
  - default timing constants;
  - bus idle constants (`CS_n`/`WR_n`/`RD_n` = 1).
- Sub-module `contador_fase_bus`: a loadable CW-bit down-counter with `load`, `valor` and `cero` outputs. It is reused by the planned read-bus stage.

## Test plan
- Default parameters, `Dato_Dire` = 0x21 after `DIR` and 0x15 after `DAT`:
  - `AD` = 0x21 with `A_D` = 0 during cycles 3–10;
  - `AD` = 0x15 with `A_D` = 1 during cycles 13–20;
  - `WR_n` low in cycles 5–8 and 15–18;
  - `cambio_estado` high in cycle 23 only.
- Sequencer model that drops `E_esc` for exactly one cycle after `cambio_estado`, run for 9 consecutive writes: exactly 9 `cambio_estado` pulses, each transaction 24 cycles apart plus one WAIT_LOW cycle.
- `E_esc` forced low in cycle 6: the transaction completes unchanged and `cambio_estado` still pulses in cycle 23.
- `reset` = 0 in cycle 16 (inside D_STB): `WR_n` = 1, `CS_n` = 1, `AD_oe` = 0 within the same cycle; after release, the block stays in IDLE until `E_esc` is high.
- `T_SETUP` = `T_PULSE` = `T_HOLD` = `T_GAP` = 1: `cambio_estado` arrives in cycle 12, `WR_n` is low for exactly 1 cycle per phase, and `RD_n` stays 1 throughout.
